instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives a word-aligned byte address to the combinational instruction memory each cycle.
- Captures the returned word into a small prefetch FIFO and presents instructions to decode with a valid/ready handshake.
- Sits between the instruction memory and the decode stage; accepts branch/jump redirects from execute.

## Interface
- RESET_PC, 32'h0000_3000, byte address of the first fetch; equals word index 0xC00 of the instruction memory.
- DEPTH, 2, prefetch FIFO entries; power of two, ≥ 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ImAddr_o  output  32  byte address to instruction memory; always equals the internal PC; bits [1:0] always 00.
- ImInstr_i  input  32  instruction word returned combinationally for ImAddr_o in the same cycle.
- Redirect_i  input  1  redirect request from execute.
- RedirectPc_i  input  32  redirect target byte address.
- Instr_o  output  32  instruction at FIFO head.
- Pc_o  output  32  byte address of Instr_o.
- Valid_o  output  1  FIFO head is valid.
- Ready_i  input  1  decode accepts the head this cycle.
- Err_o  output  1  misaligned redirect seen; sticky until rst.

## Operation
- States:
  - RUN: normal fetching.
  - HALT: entered on a misaligned redirect; left only by rst.
- Reset values (on the rst edge):
  - PC = RESET_PC.
  - FIFO empty (count 0, read and write pointers 0).
  - Valid_o = 0, Err_o = 0, state = RUN.
  - Instr_o and Pc_o = 0 while empty.
- Pop: when Valid_o && Ready_i, the head is consumed at the clock edge.
- Push (RUN, no redirect): when count < DEPTH, or count == DEPTH with a pop in the same cycle:
  - write {PC, ImInstr_i} to the tail;
  - PC += 4, 32-bit wrap-around (0xFFFF_FFFC → 0x0000_0000).
  - No push means the PC holds.
- Redirect (Redirect_i = 1 in RUN) has priority over push and pop:
  - FIFO flushed to empty; any concurrent pop is discarded and not counted as accepted;
  - no push that cycle;
  - if RedirectPc_i[1:0] == 00: PC = RedirectPc_i;
  - else: PC holds, Err_o = 1, state = HALT.
- HALT:
  - no pushes, redirects ignored, Valid_o = 0;
  - ImAddr_o keeps its last value;
  - FIFO stays empty, because the HALT entry cycle flushed it.
- Count update: count_next = count + push − pop, range 0..DEPTH. Valid_o = (count != 0).
- Instr_o and Pc_o are driven from registered FIFO storage, not combinationally from ImInstr_i.
- rst asserted in any state or mid-stream: every register returns to its reset value on that edge; in-flight entries are lost.

## Timing
- Fetch latency: word at address A on ImAddr_o in cycle n appears on Instr_o and Valid_o in cycle n+1 if the FIFO was empty.
- After rst deasserts:
  - cycle 0: ImAddr_o = RESET_PC, Valid_o = 0;
  - cycle 1: Valid_o = 1, Pc_o = RESET_PC.
- Throughput: one instruction per cycle with Ready_i held high.
- Backpressure: with Ready_i low, the FIFO fills in DEPTH cycles, then the PC stalls.
  - ImAddr_o then holds the next unfetched address.
  - That word is pushed on the first cycle Ready_i returns high, in the same cycle as the pop.
- Redirect penalty: redirect asserted in cycle n gives:
  - Valid_o = 0 in cycle n+1;
  - ImAddr_o = target in cycle n+1;
  - target instruction valid in cycle n+2.
- Back-to-back redirects: each one flushes; the last one wins.

## Test plan
- Reset/stream:
  - stimulus: rst for 2 cycles, Ready_i = 1, memory returns word = address.
  - required: Pc_o / Instr_o = 0x3000, 0x3004, 0x3008… on consecutive cycles starting 1 cycle after rst falls.
- Backpressure:
  - stimulus: Ready_i = 0 for 5 cycles from the first valid.
  - required: FIFO holds 0x3000 and 0x3004; ImAddr_o stalls at 0x3008.
  - on release: 0x3000, 0x3004, 0x3008 delivered with no gap or duplicate.
- Redirect with pop:
  - stimulus: Redirect_i = 1, RedirectPc_i = 0x3100, same cycle as Valid_o && Ready_i.
  - required: Valid_o = 0 next cycle, then Pc_o = 0x3100; no stale 0x300x entry appears.
- Misaligned redirect:
  - stimulus: RedirectPc_i = 0x3102.
  - required: Err_o = 1 next cycle and stays 1; Valid_o stays 0; later redirects ignored; rst clears Err_o and restarts at 0x3000.
- Wrap:
  - stimulus: redirect to 0xFFFF_FFFC.
  - required: Pc_o sequence 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-stream:
  - stimulus: rst with FIFO full and Ready_i = 0.
  - required: next cycle Valid_o = 0, count 0, ImAddr_o = 0x3000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Owns the program counter and drives a word-aligned byte address to a
//   combinational instruction memory. The returned word is captured, together
//   with its address, into a small prefetch FIFO. Decode takes entries from
//   the FIFO head through a valid/ready handshake. Execute can redirect the
//   fetch stream. A misaligned redirect halts the unit and sets a sticky error
//   that only rst clears.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   ImAddr_o     : byte address to instruction memory (the PC)
//   ImInstr_i    : instruction word for ImAddr_o, returned in the same cycle
//   Redirect_i   : redirect request from execute
//   RedirectPc_i : redirect target byte address
//   Instr_o      : instruction at FIFO head (0 while empty)
//   Pc_o         : byte address of Instr_o (0 while empty)
//   Valid_o      : FIFO head valid
//   Ready_i      : decode accepts the head this cycle
//   Err_o        : sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ImAddr_o,
  input  logic [31:0] ImInstr_i,
  input  logic        Redirect_i,
  input  logic [31:0] RedirectPc_i,
  output logic [31:0] Instr_o,
  output logic [31:0] Pc_o,
  output logic        Valid_o,
  input  logic        Ready_i,
  output logic        Err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fifo_pc_q    [DEPTH];
  logic [31:0]      fifo_instr_q [DEPTH];

  logic run_s, redirect_s, misaligned_s, pop_s, push_s;

  // Qualify redirect, pop and push for the current cycle.
  always_comb begin
    case (state_q)
      ST_RUN:  run_s = 1'b1;
      ST_HALT: run_s = 1'b0;
      default: run_s = 1'b0;
    endcase
    redirect_s   = run_s && Redirect_i;
    misaligned_s = redirect_s && (RedirectPc_i[1:0] != 2'b00);
    // A redirect discards any concurrent pop: the flushed head is not accepted.
    pop_s        = Valid_o && Ready_i && !redirect_s;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    push_s       = run_s && !redirect_s && ((count_q != CNT_FULL) || pop_s);
  end

  // Next-state computation for PC, FIFO control, error flag and state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_s) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (misaligned_s) begin
        // PC is left untouched so ImAddr_o keeps its last value while halted.
        err_d   = 1'b1;
        state_d = ST_HALT;
      end else begin
        pc_d = RedirectPc_i;
      end
    end else begin
      if (push_s) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      err_q    <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Prefetch storage: each entry holds the fetch address and its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= 32'h0000_0000;
        fifo_instr_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= ImInstr_i;
    end else begin
      fifo_pc_q[wr_ptr_q]    <= fifo_pc_q[wr_ptr_q];
      fifo_instr_q[wr_ptr_q] <= fifo_instr_q[wr_ptr_q];
    end
  end

  // Outputs come from registered state only; head contents are masked to 0
  // while empty so stale entries never show.
  assign ImAddr_o = pc_q;
  assign Valid_o  = (count_q != '0);
  assign Err_o    = err_q;
  assign Pc_o     = Valid_o ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;
  assign Instr_o  = Valid_o ? fifo_instr_q[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. The memory model returns
//   word = address. Expected fetch addresses go into a queue when a stream
//   starts (reset release or redirect). Each accepted handshake pops the
//   queue and compares Pc_o and Instr_o against the popped address. Inputs
//   are driven and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ImAddr_o;
  logic [31:0] ImInstr_i;
  logic        Redirect_i;
  logic [31:0] RedirectPc_i;
  logic [31:0] Instr_o;
  logic [31:0] Pc_o;
  logic        Valid_o;
  logic        Ready_i;
  logic        Err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ImAddr_o     (ImAddr_o),
    .ImInstr_i    (ImInstr_i),
    .Redirect_i   (Redirect_i),
    .RedirectPc_i (RedirectPc_i),
    .Instr_o      (Instr_o),
    .Pc_o         (Pc_o),
    .Valid_o      (Valid_o),
    .Ready_i      (Ready_i),
    .Err_o        (Err_o)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: word = address.
  assign ImInstr_i = ImAddr_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One cycle: drive inputs for the next rising edge, and score the
  // handshake that edge will complete.
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt, input logic r);
    logic [31:0] e;
    @(negedge clk);
    rst          = r;
    Ready_i      = rdy;
    Redirect_i   = redir;
    RedirectPc_i = tgt;
    if (Valid_o && rdy && !redir && !r) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", Pc_o, e);
        chk("sb_instr", Instr_o, e);
      end
    end
    if (r || redir) exp_q.delete();
  endtask

  task automatic sb_done(input string tag);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; Ready_i = 1'b0; Redirect_i = 1'b0; RedirectPc_i = 32'h0;

    // Reset, then a continuous stream
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(Valid_o), 32'd0);
    chk("rst_err",   32'(Err_o),   32'd0);
    chk("rst_addr",  ImAddr_o,     32'h0000_3000);
    chk("rst_pc",    Pc_o,         32'h0);
    chk("rst_instr", Instr_o,      32'h0);
    expect_seq(32'h0000_3000, 6);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("c0_valid", 32'(Valid_o), 32'd0);
    chk("c0_addr",  ImAddr_o,     32'h0000_3000);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stream_valid", 32'(Valid_o), 32'd1);
    end
    sb_done("stream_drain");

    // Backpressure from the first valid
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_valid", 32'(Valid_o), 32'd1);
    chk("bp_stall", ImAddr_o,     32'h0000_3008);
    chk("bp_head",  Pc_o,         32'h0000_3000);
    expect_seq(32'h0000_3000, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("bp_valid_rel", 32'(Valid_o), 32'd1);
    end
    sb_done("bp_drain");

    // Redirect in the same cycle as a handshake
    chk("rp_setup", 32'(Valid_o), 32'd1);
    cyc(1'b1, 1'b1, 32'h0000_3100, 1'b0);
    expect_seq(32'h0000_3100, 3);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rp_valid", 32'(Valid_o), 32'd0);
    chk("rp_addr",  ImAddr_o,     32'h0000_3100);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    sb_done("rp_drain");

    // Back-to-back redirects: the last one wins
    cyc(1'b1, 1'b1, 32'h0000_3200, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_3300, 1'b0);
    expect_seq(32'h0000_3300, 2);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("b2b_valid", 32'(Valid_o), 32'd0);
    chk("b2b_addr",  ImAddr_o,     32'h0000_3300);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    sb_done("b2b_drain");

    // PC wrap-around
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    expect_seq(32'hFFFF_FFFC, 3);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    sb_done("wrap_drain");

    // Misaligned redirect: halt with a sticky error, PC holds at 0xC
    cyc(1'b1, 1'b1, 32'h0000_3102, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_err",   32'(Err_o),   32'd1);
    chk("mis_valid", 32'(Valid_o), 32'd0);
    chk("mis_addr",  ImAddr_o,     32'h0000_000C);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 32'h0000_4000, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("halt_err",   32'(Err_o),   32'd1);
      chk("halt_valid", 32'(Valid_o), 32'd0);
      chk("halt_addr",  ImAddr_o,     32'h0000_000C);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("clr_err",  32'(Err_o), 32'd0);
    chk("clr_addr", ImAddr_o,   32'h0000_3000);
    expect_seq(32'h0000_3000, 3);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    sb_done("restart_drain");

    // Reset with the FIFO full and decode stalled
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_full_valid", 32'(Valid_o), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_valid", 32'(Valid_o), 32'd0);
    chk("mid_addr",  ImAddr_o,     32'h0000_3000);
    chk("mid_pc",    Pc_o,         32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mid_first", Pc_o, 32'h0000_3000);
    sb_done("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
